hazard_stall_ctrl: RTL and testbench

- Pipeline interlock controller for the 5-stage RV32I core (IF, ID, EX, MEM, WB).
- Consumes the ID stage's register-use signals (rs1_re/rs1_addr, rs2_re/rs2_addr, rd_we/rd_addr) and keeps a scoreboard of in-flight destination registers.
- Generates stall, bubble and flush controls for the IF/ID and ID/EX pipeline registers.
- No forwarding network exists: every RAW hazard is resolved by interlock.
- Also sequences EX redirect flushes and memory-busy freezes, and counts stall cycles.

---
 rtl/hazard_stall_ctrl.sv | 86 ++++++++
 tb/tb_hazard_stall_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: RAW interlock, redirect flush and memory-freeze sequencing for a 5-stage pipeline.
module hazard_stall_ctrl #(
    parameter int DEPTH            = 3,
    parameter bit RF_WRITE_THROUGH = 1'b1,
    parameter int FLUSH_CYCLES     = 1,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic                 rs1_re,
    input  logic [4:0]           rs1_addr,
    input  logic                 rs2_re,
    input  logic [4:0]           rs2_addr,
    input  logic                 rd_we,
    input  logic [4:0]           rd_addr,
    input  logic                 ex_redirect,
    input  logic                 mem_busy,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 bubble_ex,
    output logic                 flush_if,
    output logic                 flush_id,
    output logic                 freeze,
    output logic [CNT_WIDTH-1:0] stall_cnt
);
    localparam int CMP = RF_WRITE_THROUGH ? DEPTH - 1 : DEPTH;
    logic [DEPTH-1:0]     sb_v_q, sb_v_d;
    logic [4:0]           sb_a_q [DEPTH];
    logic [4:0]           sb_a_d [DEPTH];
    logic                 redirect_pend_q, redirect_pend_d;
    logic [2:0]           flush_ctr_q, flush_ctr_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic                 hit1, hit2, hazard, redirect_eff, flush_active, issue;
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < CMP; i++) begin
            hit1 = hit1 | (sb_v_q[i] && sb_a_q[i] == rs1_addr);
            hit2 = hit2 | (sb_v_q[i] && sb_a_q[i] == rs2_addr);
        end
        hazard       = id_valid && ((rs1_re && rs1_addr != 5'd0 && hit1) || (rs2_re && rs2_addr != 5'd0 && hit2));
        redirect_eff = (ex_redirect || redirect_pend_q) && !mem_busy;
        flush_active = flush_ctr_q != 3'd0 || redirect_eff;
        issue        = id_valid && !hazard && !flush_active && !mem_busy;
    end
    always_comb begin
        freeze    = !rst && mem_busy;
        stall_if  = !rst && (mem_busy || (!flush_active && hazard));
        stall_id  = stall_if;
        flush_if  = rst || (!mem_busy && flush_active);
        flush_id  = flush_if;
        bubble_ex = rst || (!mem_busy && (flush_active || hazard));
        stall_cnt = stall_cnt_q;
    end
    // A frozen memory stage holds everything except a redirect, which is parked until the freeze lifts.
    always_comb begin
        sb_v_d          = sb_v_q;
        sb_a_d          = sb_a_q;
        redirect_pend_d = redirect_pend_q | ex_redirect;
        flush_ctr_d     = flush_ctr_q;
        stall_cnt_d     = stall_cnt_q;
        if (!mem_busy) begin
            sb_v_d          = DEPTH'({sb_v_q, issue && rd_we && rd_addr != 5'd0});
            sb_a_d[0]       = rd_addr;
            for (int i = 1; i < DEPTH; i++) sb_a_d[i] = sb_a_q[i-1];
            redirect_pend_d = 1'b0;
            flush_ctr_d     = redirect_eff ? 3'(FLUSH_CYCLES - 1) : flush_ctr_q - {2'b0, flush_ctr_q != 3'd0};
            stall_cnt_d     = (!flush_active && hazard && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        end
    end
    always_ff @(posedge clk) begin
        sb_a_q <= sb_a_d;
        if (rst) begin
            sb_v_q          <= '0;
            redirect_pend_q <= 1'b0;
            flush_ctr_q     <= 3'd0;
            stall_cnt_q     <= '0;
        end else begin
            sb_v_q          <= sb_v_d;
            redirect_pend_q <= redirect_pend_d;
            flush_ctr_q     <= flush_ctr_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: per-register age model of the interlock, directed scenarios plus random traffic.
module tb_hazard_stall_ctrl;
    localparam int DEPTH = 3;
    localparam bit RWT   = 1'b1;
    localparam int FC    = 2;
    localparam int CW    = 4;
    localparam int CMP   = RWT ? DEPTH - 1 : DEPTH;
    logic clk = 1'b0, rst = 1'b1;
    logic id_valid = 0, rs1_re = 0, rs2_re = 0, rd_we = 0, ex_redirect = 0, mem_busy = 0;
    logic [4:0] rs1_addr = 0, rs2_addr = 0, rd_addr = 0;
    logic stall_if, stall_id, bubble_ex, flush_if, flush_id, freeze;
    logic [CW-1:0] stall_cnt;
    int checks = 0, errors = 0;
    hazard_stall_ctrl #(.DEPTH(DEPTH), .RF_WRITE_THROUGH(RWT), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .rs1_re(rs1_re), .rs1_addr(rs1_addr),
        .rs2_re(rs2_re), .rs2_addr(rs2_addr), .rd_we(rd_we), .rd_addr(rd_addr),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy), .stall_if(stall_if), .stall_id(stall_id),
        .bubble_ex(bubble_ex), .flush_if(flush_if), .flush_id(flush_id), .freeze(freeze), .stall_cnt(stall_cnt)
    );
    always #5 clk = ~clk;
    // Model: each register remembers when its newest writer issued, counted in unfrozen cycles.
    int  adv = 0, fleft = 0, cnt = 0;
    bit  pend = 0, started = 0;
    bit  wv [32];
    int  wt [32];
    int  age1, age2;
    bit  m_haz, m_redir, m_flush;
    always_comb begin
        age1    = adv - wt[rs1_addr];
        age2    = adv - wt[rs2_addr];
        m_haz   = id_valid && ((rs1_re && rs1_addr != 0 && wv[rs1_addr] && age1 >= 1 && age1 <= CMP) ||
                               (rs2_re && rs2_addr != 0 && wv[rs2_addr] && age2 >= 1 && age2 <= CMP));
        m_redir = (ex_redirect || pend) && !mem_busy;
        m_flush = fleft > 0 || m_redir;
    end
    always @(posedge clk) begin
        bit h, f, r, iss;
        h = m_haz; f = m_flush; r = m_redir;
        iss = id_valid && !h && !f && !mem_busy;
        started = 1'b1;
        if (rst) begin
            for (int k = 0; k < 32; k++) wv[k] = 1'b0;
            pend = 0; fleft = 0; cnt = 0;
        end else if (mem_busy) begin
            pend = pend | ex_redirect;
        end else begin
            if (iss && rd_we && rd_addr != 0) begin
                wv[rd_addr] = 1'b1;
                wt[rd_addr] = adv;
            end
            adv++;
            if (r) begin fleft = FC - 1; pend = 0; end
            else if (fleft > 0) fleft--;
            if (!f && h && cnt < (1 << CW) - 1) cnt++;
        end
    end
    always @(negedge clk) begin
        logic [5+CW:0] e, a;
        if (started) begin
            e = {!rst && (mem_busy || (!m_flush && m_haz)), !rst && (mem_busy || (!m_flush && m_haz)),
                 rst || (!mem_busy && (m_flush || m_haz)), rst || (!mem_busy && m_flush),
                 rst || (!mem_busy && m_flush), !rst && mem_busy, CW'(cnt)};
            a = {stall_if, stall_id, bubble_ex, flush_if, flush_id, freeze, stall_cnt};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL model t=%0t got %b want %b (stall_if,stall_id,bubble,flush_if,flush_id,freeze,cnt)", $time, a, e);
            end
        end
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask
    task automatic drv(input bit v, input bit r1e, input int r1, input bit r2e, input int r2,
                       input bit we, input int rd, input bit rdr, input bit busy);
        id_valid = v; rs1_re = r1e; rs1_addr = 5'(r1); rs2_re = r2e; rs2_addr = 5'(r2);
        rd_we = we; rd_addr = 5'(rd); ex_redirect = rdr; mem_busy = busy;
        #2;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_flush_id", flush_id, 1);
        chk("rst_bubble", bubble_ex, 1);
        tick(); tick();
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("idle_out", {stall_if, stall_id, bubble_ex, flush_if, flush_id, freeze}, 0);
        chk("idle_cnt", stall_cnt, 0);
        tick();
        drv(1, 0, 0, 0, 0, 1, 5, 0, 0);
        chk("prod_issue", stall_if, 0);
        tick();
        drv(1, 1, 5, 0, 0, 0, 0, 0, 0);
        chk("raw_stall1", {stall_if, stall_id, bubble_ex}, 3'b111);
        tick();
        chk("raw_stall2", {stall_if, stall_id, bubble_ex}, 3'b111);
        tick();
        chk("raw_issue", {stall_if, bubble_ex}, 0);
        chk("raw_cnt", stall_cnt, 2);
        tick();
        drv(1, 0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        drv(1, 1, 0, 1, 0, 1, 7, 0, 0);
        chk("x0_nostall", stall_if, 0);
        tick();
        drv(1, 1, 3, 0, 7, 0, 0, 0, 0);
        chk("noread_nostall", stall_if, 0);
        tick();
        drv(1, 0, 0, 0, 0, 1, 9, 0, 0);
        tick();
        drv(1, 1, 9, 0, 0, 0, 0, 1, 0);
        chk("redir_c1", {flush_if, flush_id, stall_if, stall_id}, 4'b1100);
        tick();
        drv(1, 1, 9, 0, 0, 0, 0, 0, 0);
        chk("redir_c2", {flush_if, flush_id, stall_if}, 3'b110);
        tick();
        chk("redir_end", {flush_if, stall_if}, 0);
        chk("redir_cnt", stall_cnt, 2);
        tick();
        drv(1, 0, 0, 0, 0, 1, 11, 0, 0);
        tick();
        for (int c = 0; c < 3; c++) begin
            drv(1, 1, 11, 0, 0, 0, 0, c == 0, 1);
            chk("busy_out", {freeze, stall_if, stall_id, bubble_ex, flush_if}, 5'b11100);
            tick();
        end
        drv(1, 1, 11, 0, 0, 0, 0, 0, 0);
        chk("busy_fall_flush", {freeze, flush_if, flush_id}, 3'b011);
        tick();
        chk("busy_flush2", flush_if, 1);
        tick();
        for (int n = 0; n < 10; n++) begin
            drv(1, 0, 0, 0, 0, 1, 12, 0, 0);
            tick();
            drv(1, 1, 12, 0, 0, 0, 0, 0, 0);
            tick(); tick(); tick();
        end
        chk("sat_cnt", stall_cnt, 15);
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        #2;
        chk("rst_cnt", stall_cnt, 0);
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            drv($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
            tick();
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
